// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment receiver: legal digit patterns,
// the blank terminator and the receiver FSM states.
package seg7_pkg;

    // Bit order is {g,f,e,d,c,b,a}; a 1 means the segment is lit.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7C;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h67;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } rx_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Purely combinational pattern decoder: maps one segment pattern to a BCD
// digit and flags whether it is a legal digit or the blank terminator.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] digit_o,
    output logic       legal_o,
    output logic       blank_o
);

    // Anything not listed (including near-miss variants such as a 6 with
    // segment a lit) falls through to illegal.
    always_comb begin
        digit_o = 4'd0;
        legal_o = 1'b1;
        blank_o = 1'b0;
        case (seg_i)
            SEG_0:     digit_o = 4'd0;
            SEG_1:     digit_o = 4'd1;
            SEG_2:     digit_o = 4'd2;
            SEG_3:     digit_o = 4'd3;
            SEG_4:     digit_o = 4'd4;
            SEG_5:     digit_o = 4'd5;
            SEG_6:     digit_o = 4'd6;
            SEG_7:     digit_o = 4'd7;
            SEG_8:     digit_o = 4'd8;
            SEG_9:     digit_o = 4'd9;
            SEG_BLANK: begin
                legal_o = 1'b0;
                blank_o = 1'b1;
            end
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_to_bcd_rx.sv
// Collects a stream of seven-segment digit patterns into a packed BCD word,
// first digit most significant, and hands the word out on a ready/valid port.
module seg7_to_bcd_rx
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg_in,
    input  logic                  seg_valid,
    output logic                  seg_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    input  logic                  bcd_ready,
    output logic                  err
);

    localparam int              CW         = $clog2(DIGITS + 1);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DIGITS);

    rx_state_e             state_q, state_d;
    logic [4*DIGITS-1:0]   word_q, word_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  err_q, err_d;

    logic [3:0]            digit;
    logic                  legal;
    logic                  blank;
    logic [CW-1:0]         countInc;
    logic                  accept;

    seg7_decode u_decode (
        .seg_i   (seg_in),
        .digit_o (digit),
        .legal_o (legal),
        .blank_o (blank)
    );

    // Handshake outputs come straight from state so no input reaches them.
    assign seg_ready = (state_q == COLLECT);
    assign bcd_valid = (state_q == HOLD);
    assign bcd_out   = word_q;
    assign err       = err_q;

    assign accept   = seg_valid && (state_q == COLLECT);
    assign countInc = count_q + CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
            word_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Shifting left leaves zeros above a short word, so an early blank
    // naturally yields a right-aligned result.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        count_d = count_q;
        err_d   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (legal) begin
                        word_d      = word_q << 4;
                        word_d[3:0] = digit;
                        count_d     = countInc;
                        if (countInc == FULL_COUNT) begin
                            state_d = HOLD;
                        end
                    end else if (blank) begin
                        if (count_q != '0) begin
                            state_d = HOLD;
                        end
                    end else begin
                        err_d   = 1'b1;
                        word_d  = '0;
                        count_d = '0;
                    end
                end
            end
            HOLD: begin
                if (bcd_ready) begin
                    state_d = COLLECT;
                    word_d  = '0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = COLLECT;
                word_d  = '0;
                count_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_seg7_to_bcd_rx.sv
// Self-checking bench for seg7_to_bcd_rx: directed scenarios followed by a
// pattern sweep and random traffic, checked against a digit-queue model.
module tb_seg7_to_bcd_rx;

    localparam int DIGITS = 4;

    logic                clk;
    logic                reset;
    logic [6:0]          seg_in;
    logic                seg_valid;
    logic                seg_ready;
    logic [4*DIGITS-1:0] bcd_out;
    logic                bcd_valid;
    logic                bcd_ready;
    logic                err;

    int nAsserts = 0;
    int nFail    = 0;
    int errCount = 0;

    int segTable[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                         7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};

    int digits[$];
    int expWord;
    bit wordPending;

    seg7_to_bcd_rx #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_in    (seg_in),
        .seg_valid (seg_valid),
        .seg_ready (seg_ready),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .bcd_ready (bcd_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err === 1'b1) errCount++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lookupDigit(input logic [6:0] p);
        for (int i = 0; i < 10; i++) begin
            if (segTable[i] == int'(p)) return i;
        end
        return -1;
    endfunction

    // Drives one pattern for one accepted cycle and checks the cycle after.
    task automatic applyStimulus(input logic [6:0] p);
        int idx;
        bit expErr;
        @(negedge clk);
        checkOutput("seg_ready_idle", seg_ready, 1);
        checkOutput("err_idle", err, 0);
        seg_in    = p;
        seg_valid = 1'b1;
        idx         = lookupDigit(p);
        expErr      = 1'b0;
        wordPending = 1'b0;
        if (idx >= 0) begin
            digits.push_back(idx);
            if (digits.size() == DIGITS) wordPending = 1'b1;
        end else if (p == 7'h00) begin
            if (digits.size() > 0) wordPending = 1'b1;
        end else begin
            expErr = 1'b1;
            digits.delete();
        end
        if (wordPending) begin
            expWord = 0;
            foreach (digits[i]) expWord = expWord * 16 + digits[i];
            digits.delete();
        end
        @(negedge clk);
        seg_valid = 1'b0;
        seg_in    = 7'($urandom_range(0, 127));
        checkOutput("err_after_accept", err, expErr);
        checkOutput("bcd_valid_after_accept", bcd_valid, wordPending);
        checkOutput("seg_ready_after_accept", seg_ready, !wordPending);
        if (wordPending) checkOutput("bcd_out_word", bcd_out, expWord);
    endtask

    // Holds the word for holdCycles with the producer still offering digits.
    task automatic drainWord(input int holdCycles);
        bcd_ready = 1'b0;
        for (int i = 0; i < holdCycles; i++) begin
            seg_in    = 7'(segTable[$urandom_range(0, 9)]);
            seg_valid = 1'b1;
            @(negedge clk);
            checkOutput("hold_bcd_valid", bcd_valid, 1);
            checkOutput("hold_seg_ready", seg_ready, 0);
            checkOutput("hold_bcd_out", bcd_out, expWord);
        end
        bcd_ready = 1'b1;
        seg_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_xfer_bcd_valid", bcd_valid, 0);
        checkOutput("post_xfer_seg_ready", seg_ready, 1);
        checkOutput("post_xfer_bcd_out", bcd_out, 0);
        wordPending = 1'b0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset     = 1'b1;
        seg_valid = 1'b0;
        @(negedge clk);
        checkOutput("err_in_reset", err, 0);
        reset = 1'b0;
        digits.delete();
        wordPending = 1'b0;
        @(negedge clk);
        checkOutput("rst_seg_ready", seg_ready, 1);
        checkOutput("rst_bcd_valid", bcd_valid, 0);
        checkOutput("rst_bcd_out", bcd_out, 0);
        checkOutput("rst_err", err, 0);
    endtask

    task automatic sendAndDrain(input logic [6:0] p, input int holdCycles);
        applyStimulus(p);
        if (wordPending) drainWord(holdCycles);
    endtask

    initial begin
        int errBefore;
        int r;
        reset     = 1'b1;
        seg_in    = 7'h00;
        seg_valid = 1'b0;
        bcd_ready = 1'b1;
        wordPending = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("init_seg_ready", seg_ready, 1);
        checkOutput("init_bcd_valid", bcd_valid, 0);
        checkOutput("init_bcd_out", bcd_out, 0);
        checkOutput("init_err", err, 0);

        sendAndDrain(7'h06, 0);
        sendAndDrain(7'h5B, 0);
        sendAndDrain(7'h4F, 0);
        sendAndDrain(7'h66, 0);
        checkOutput("word_1234_seen", expWord, 32'h1234);

        sendAndDrain(7'h7C, 0);
        sendAndDrain(7'h07, 0);
        sendAndDrain(7'h00, 0);
        checkOutput("word_0067_seen", expWord, 32'h0067);
        errBefore = errCount;
        sendAndDrain(7'h00, 0);
        checkOutput("lone_blank_no_word", wordPending, 0);
        checkOutput("lone_blank_no_err", errCount - errBefore, 0);

        sendAndDrain(7'h3F, 0);
        sendAndDrain(7'h6D, 0);
        errBefore = errCount;
        sendAndDrain(7'h7D, 0);
        sendAndDrain(7'h7F, 0);
        checkOutput("bad6_one_err", errCount - errBefore, 1);
        sendAndDrain(7'h67, 0);
        sendAndDrain(7'h3F, 0);
        sendAndDrain(7'h06, 0);
        checkOutput("word_8901_seen", expWord, 32'h8901);

        sendAndDrain(7'h4F, 0);
        sendAndDrain(7'h07, 0);
        sendAndDrain(7'h3F, 0);
        sendAndDrain(7'h6D, 5);
        sendAndDrain(7'h06, 0);
        sendAndDrain(7'h00, 0);
        checkOutput("after_hold_fresh_word", expWord, 32'h0001);

        sendAndDrain(7'h5B, 0);
        sendAndDrain(7'h66, 0);
        applyReset();
        sendAndDrain(7'h06, 0);
        sendAndDrain(7'h00, 0);
        checkOutput("after_midword_reset", expWord, 32'h0001);

        sendAndDrain(7'h06, 0);
        sendAndDrain(7'h5B, 0);
        sendAndDrain(7'h4F, 0);
        applyStimulus(7'h66);
        bcd_ready = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_hold", bcd_valid, 1);
        errBefore = errCount;
        applyReset();
        checkOutput("hold_reset_no_err", errCount - errBefore, 0);
        bcd_ready = 1'b1;
        sendAndDrain(7'h7F, 0);
        sendAndDrain(7'h07, 0);
        sendAndDrain(7'h00, 0);
        checkOutput("after_hold_reset", expWord, 32'h0087);

        errBefore = errCount;
        for (int p = 0; p < 128; p++) begin
            sendAndDrain(7'(p), 0);
            sendAndDrain(7'h00, 0);
        end
        checkOutput("sweep_err_count", errCount - errBefore, 117);

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 19);
            if (r < 14)      sendAndDrain(7'(segTable[$urandom_range(0, 9)]), $urandom_range(0, 3));
            else if (r < 17) sendAndDrain(7'h00, $urandom_range(0, 3));
            else             sendAndDrain(7'($urandom_range(0, 127)), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/seg7_to_bcd_rx.md
SEG7_TO_BCD_RX -- requirements
Module: seg7_to_bcd_rx

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of BCD digits per output word (legal range 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port seg_in, input, 7 bits, segment pattern; bit0=a, bit1=b, …, bit6=g; 1 = segment lit.
REQ-005 The block SHALL have port seg_valid, input, 1 bit, seg_in carries a pattern this cycle.
REQ-006 The block SHALL have port seg_ready, output, 1 bit, the block accepts a pattern this cycle.
REQ-007 The block SHALL have port bcd_out, output, 4*DIGITS bits, packed BCD word; digit 0 in [3:0].
REQ-008 The block SHALL have port bcd_valid, output, 1 bit, bcd_out holds a complete word.
REQ-009 The block SHALL have port bcd_ready, input, 1 bit, the consumer takes the word.
REQ-010 The block SHALL have port err, output, 1 bit, one-cycle pulse on an illegal pattern.

Function
REQ-011 A pattern SHALL be accepted only in a cycle with seg_valid=1 and seg_ready=1.
REQ-012 The legal digit patterns SHALL be exactly 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7C, 7=0x07, 8=0x7F, 9=0x67 (6 without a, 7 without f, 9 without d).
REQ-013 Pattern 0x00 (blank) SHALL be the word terminator; every other pattern SHALL be illegal.
REQ-014 The FSM SHALL have two states: COLLECT (seg_ready=1, bcd_valid=0) and HOLD (seg_ready=0, bcd_valid=1).
REQ-015 In COLLECT, an accepted legal digit SHALL shift the word left 4 bits, insert the digit into [3:0] and increment digit count; the first digit received is therefore most significant.
REQ-016 When the accepted digit makes the count equal DIGITS, the FSM SHALL enter HOLD; bcd_valid SHALL rise the cycle after acceptance (latency 1).
REQ-017 An accepted blank with count>0 SHALL enter HOLD with the collected digits right-aligned and the unused upper digits 0.
REQ-018 An accepted blank with count=0 SHALL be ignored; no state change, no err.
REQ-019 An accepted illegal pattern SHALL pulse err for exactly the next cycle, clear the word and count, and remain in COLLECT.
REQ-020 In HOLD, bcd_out SHALL stay stable until bcd_ready=1; that cycle completes the transfer and the next cycle SHALL be COLLECT with word and count cleared.
REQ-021 In HOLD, seg_in and seg_valid SHALL be ignored.
REQ-022 Handshaking SHALL not use combinational paths: seg_ready and bcd_valid SHALL be registered or decoded from state only.

Reset
REQ-023 Reset SHALL force COLLECT, count=0, bcd_out=0, bcd_valid=0, err=0 and seg_ready=1 in the cycle after reset falls.
REQ-024 Reset asserted mid-word or during HOLD SHALL discard the partial or held word without an err pulse.

Structure
REQ-025 A shared package seg7_pkg SHALL hold the ten digit pattern constants, the blank constant and the FSM state enum.
REQ-026 Pattern decoding SHALL sit in one combinational sub-module, seg7_decode (seg_in -> 4-bit digit, legal flag, blank flag).
REQ-027 The digit counter SHALL be sized to hold 0..DIGITS.

Verification
REQ-028 DIGITS=4; send 0x06,0x5B,0x4F,0x66 with bcd_ready=1 -> bcd_out=0x1234 with bcd_valid high one cycle, then seg_ready=1.
REQ-029 Send 0x7C,0x07,0x00 -> bcd_out=0x0067 (early termination); then send blank alone -> no word, no err.
REQ-030 Send 0x3F,0x6D,0x7D (6 with segment a) -> err pulses one cycle; then 0x7F,0x67,0x3F,0x06 -> bcd_out=0x8901.
REQ-031 Complete a word with bcd_ready=0 for 5 cycles while seg_valid=1 -> seg_ready=0, bcd_out stable at its value, no digits lost; release bcd_ready -> transfer, then COLLECT.
REQ-032 Assert reset after two digits and again during HOLD -> outputs return to their REQ-023 values; next word decodes cleanly from an empty register.
REQ-033 Sweep all 128 patterns one at a time, each followed by blank -> err for exactly the 117 non-legal, non-blank codes.
